// File: rtl/pstprc_iq_collector.sv
// Collects 64-bit I/Q demod results per trigger into a small buffer and
// replays them upstream as a header word followed by interleaved I/Q words.
module pstprc_iq_collector #(
    parameter int          C_DEPTH   = 16,
    parameter logic [15:0] C_HDR_TAG = 16'hA5C3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        posedge_sample_trig,
    input  logic [63:0] pstprc_IQ_seq_i,
    input  logic        pstprc_fifo_wren,
    input  logic        Pstprc_finish,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        frame_last,
    output logic [15:0] trig_cnt,
    output logic [15:0] miss_cnt,
    output logic        ovf_flag,
    output logic        busy
);

    localparam int AW = $clog2(C_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        HEADER,
        SEND_I,
        SEND_Q,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] n_res_q, n_res_d;
    logic          fin_pend_q, fin_pend_d;
    logic [15:0]   trig_cnt_q, trig_cnt_d;
    logic [15:0]   miss_cnt_q, miss_cnt_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   fdata_q, fdata_d;
    logic          fvalid_q, fvalid_d;
    logic          flast_q, flast_d;

    logic [63:0]   mem [C_DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [63:0]   rd_word;
    logic [7:0]    nres8;
    logic          xfer;

    assign xfer    = fvalid_q & frame_ready;
    assign rd_word = mem[rd_ptr_d[AW-1:0]];
    assign nres8   = 8'(n_res_d);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        n_res_d    = n_res_q;
        fin_pend_d = fin_pend_q;
        trig_cnt_d = trig_cnt_q;
        miss_cnt_d = miss_cnt_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q[AW-1:0];

        if (posedge_sample_trig && state_q != IDLE && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (posedge_sample_trig) begin
                    state_d    = COLLECT;
                    wr_ptr_d   = '0;
                    fin_pend_d = 1'b0;
                    trig_cnt_d = trig_cnt_q + 16'd1;
                end
            end
            COLLECT: begin
                // One extra cycle after finish gives the two-cycle header latency.
                if (fin_pend_q) begin
                    state_d    = HEADER;
                    fin_pend_d = 1'b0;
                end else begin
                    if (pstprc_fifo_wren) begin
                        if (wr_ptr_q < PW'(C_DEPTH)) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (Pstprc_finish) begin
                        n_res_d    = wr_ptr_d;
                        fin_pend_d = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (xfer) begin
                    if (n_res_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SEND_I;
                        rd_ptr_d = '0;
                    end
                end
            end
            SEND_I: begin
                if (xfer) state_d = SEND_Q;
            end
            SEND_Q: begin
                if (xfer) begin
                    if (rd_ptr_q == n_res_q - PW'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SEND_I;
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output word is computed from the next state so the port registers line up with state_q.
    always_comb begin
        fvalid_d = (state_d == HEADER) || (state_d == SEND_I) || (state_d == SEND_Q);
        fdata_d  = '0;
        flast_d  = 1'b0;
        case (state_d)
            HEADER: begin
                fdata_d = {C_HDR_TAG, trig_cnt_d[7:0], nres8};
                flast_d = (n_res_d == '0);
            end
            SEND_I:  fdata_d = rd_word[63:32];
            SEND_Q: begin
                fdata_d = rd_word[31:0];
                flast_d = (rd_ptr_d == n_res_d - PW'(1));
            end
            default: begin
                fdata_d = '0;
                flast_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            n_res_q    <= '0;
            fin_pend_q <= 1'b0;
            trig_cnt_q <= '0;
            miss_cnt_q <= '0;
            ovf_q      <= 1'b0;
            fdata_q    <= '0;
            fvalid_q   <= 1'b0;
            flast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            n_res_q    <= n_res_d;
            fin_pend_q <= fin_pend_d;
            trig_cnt_q <= trig_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            ovf_q      <= ovf_d;
            fdata_q    <= fdata_d;
            fvalid_q   <= fvalid_d;
            flast_q    <= flast_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= pstprc_IQ_seq_i;
    end

    assign frame_data  = fdata_q;
    assign frame_valid = fvalid_q;
    assign frame_last  = flast_q;
    assign trig_cnt    = trig_cnt_q;
    assign miss_cnt    = miss_cnt_q;
    assign ovf_flag    = ovf_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pstprc_iq_collector.sv
// Randomized bench for pstprc_iq_collector against a frame-level reference model.
module tb_pstprc_iq_collector;

    localparam int          DEPTH = 16;
    localparam logic [15:0] TAG   = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig;
    logic [63:0] data;
    logic        wren;
    logic        fin;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_last;
    logic [15:0] trig_cnt;
    logic [15:0] miss_cnt;
    logic        ovf_flag;
    logic        busy;

    always #5 clk = ~clk;

    pstprc_iq_collector #(.C_DEPTH(DEPTH), .C_HDR_TAG(TAG)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .posedge_sample_trig (trig),
        .pstprc_IQ_seq_i     (data),
        .pstprc_fifo_wren    (wren),
        .Pstprc_finish       (fin),
        .frame_data          (frame_data),
        .frame_valid         (frame_valid),
        .frame_ready         (frame_ready),
        .frame_last          (frame_last),
        .trig_cnt            (trig_cnt),
        .miss_cnt            (miss_cnt),
        .ovf_flag            (ovf_flag),
        .busy                (busy)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] mdl_trig;
    int          mdl_miss;
    logic        mdl_ovf;
    logic [32:0] exp_w[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        trig = 0; wren = 0; fin = 0; frame_ready = 0; data = '0;
        rst_n = 0;
        repeat (2) tick;
        rst_n = 1;
        tick;
        mdl_trig = 0; mdl_miss = 0; mdl_ovf = 0;
    endtask

    // Drives one trigger/results/finish sequence, then drains the frame with the
    // given ready pattern (0: always, 1: toggle, 2: random) and checks every word.
    task automatic run_frame(input int nwr, input int rmode, input bit simul,
                             input bit rnd, input bit miss_in_collect, output int nwords);
        logic [63:0] res[$];
        logic [32:0] prev;
        bit          stalled;
        int          idx;
        int          n;
        bit          r;
        res.delete();
        exp_w.delete();
        frame_ready = 0;
        trig = 1;
        tick;
        trig = 0;
        mdl_trig = mdl_trig + 16'd1;
        checks++;
        if (trig_cnt !== mdl_trig || busy !== 1'b1) begin
            failures++;
            $display("FAIL frame_open: trig_cnt=%h busy=%b required trig_cnt=%h busy=1", trig_cnt, busy, mdl_trig);
        end
        for (int k = 0; k < nwr; k++) begin
            if (rnd && $urandom_range(3) == 0) tick;
            data = rnd ? {$urandom, $urandom} : {32'(k), 32'(256 + k)};
            wren = 1;
            if (miss_in_collect && k == 0) begin
                trig = 1;
                if (mdl_miss < 16'hFFFF) mdl_miss++;
            end
            if (simul && k == nwr - 1) fin = 1;
            res.push_back(data);
            tick;
            trig = 0; wren = 0; fin = 0;
        end
        if (!(simul && nwr > 0)) begin
            fin = 1;
            tick;
            fin = 0;
        end
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: frame_valid=%b one cycle after finish, required 0", frame_valid);
        end
        tick;
        checks++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency: frame_valid=%b two cycles after finish, required 1", frame_valid);
        end

        n = (res.size() > DEPTH) ? DEPTH : res.size();
        if (res.size() > DEPTH) mdl_ovf = 1;
        exp_w.push_back({(n == 0), TAG, mdl_trig[7:0], 8'(n)});
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({1'b0, res[i][63:32]});
            exp_w.push_back({(i == n - 1), res[i][31:0]});
        end

        idx = 0;
        stalled = 0;
        prev = '0;
        for (int cyc = 0; cyc < 400 && idx < exp_w.size(); cyc++) begin
            if (stalled) begin
                checks++;
                if (frame_valid !== 1'b1 || {frame_last, frame_data} !== prev) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%b last/data=%h required valid=1 last/data=%h", frame_valid, {frame_last, frame_data}, prev);
                end
            end
            checks++;
            if (frame_valid !== 1'b1) begin
                failures++;
                $display("FAIL valid_drop: frame_valid=%b at word %0d, required 1", frame_valid, idx);
                break;
            end
            case (rmode)
                0:       r = 1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(1));
            endcase
            frame_ready = r;
            if (r) begin
                checks++;
                if ({frame_last, frame_data} !== exp_w[idx]) begin
                    failures++;
                    $display("FAIL word%0d: last/data=%h required %h", idx, {frame_last, frame_data}, exp_w[idx]);
                end
                idx++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev = {frame_last, frame_data};
            end
            tick;
        end
        frame_ready = 0;
        nwords = idx;
        checks++;
        if (idx != exp_w.size()) begin
            failures++;
            $display("FAIL frame_timeout: transferred %0d words, required %0d", idx, exp_w.size());
        end
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_state: valid=%b busy=%b required valid=0 busy=1", frame_valid, busy);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || ovf_flag !== mdl_ovf || miss_cnt !== 16'(mdl_miss)) begin
            failures++;
            $display("FAIL frame_end: busy=%b ovf=%b miss=%0d required busy=0 ovf=%b miss=%0d", busy, ovf_flag, miss_cnt, mdl_ovf, mdl_miss);
        end
    endtask

    task automatic test_reset;
        trig = 0; wren = 0; fin = 0; frame_ready = 0; data = '0;
        rst_n = 0;
        #1;
        checks++;
        if ({frame_data, frame_valid, frame_last, trig_cnt, miss_cnt, ovf_flag, busy} !== '0) begin
            failures++;
            $display("FAIL reset_state: data=%h valid=%b last=%b trig=%h miss=%h ovf=%b busy=%b required all 0",
                     frame_data, frame_valid, frame_last, trig_cnt, miss_cnt, ovf_flag, busy);
        end
        do_reset;
    endtask

    task automatic test_basic;
        int nw;
        run_frame(12, 0, 0, 0, 0, nw);
        checks++;
        if (nw != 25) begin
            failures++;
            $display("FAIL basic_count: %0d words required 25", nw);
        end
    endtask

    task automatic test_backpressure;
        int nw;
        run_frame(12, 1, 0, 0, 0, nw);
        checks++;
        if (nw != 25) begin
            failures++;
            $display("FAIL bp_count: %0d words required 25", nw);
        end
    endtask

    task automatic test_simultaneous;
        int nw;
        run_frame(3, 0, 1, 0, 0, nw);
        checks++;
        if (nw != 7) begin
            failures++;
            $display("FAIL simul_count: %0d words required 7", nw);
        end
    endtask

    task automatic test_overflow;
        int nw;
        run_frame(20, 0, 0, 0, 0, nw);
        checks++;
        if (nw != 33 || ovf_flag !== 1'b1) begin
            failures++;
            $display("FAIL overflow: %0d words ovf=%b required 33 words ovf=1", nw, ovf_flag);
        end
    endtask

    task automatic test_empty_and_miss;
        do_reset;
        for (int k = 0; k < 20; k++) begin
            wren = 1;
            data = {$urandom, $urandom};
            fin = (k == 10);
            tick;
        end
        wren = 0; fin = 0;
        tick;
        checks++;
        if (ovf_flag !== 1'b0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore: ovf=%b busy=%b valid=%b required 0 0 0", ovf_flag, busy, frame_valid);
        end
        trig = 1; tick; trig = 0;
        mdl_trig = mdl_trig + 16'd1;
        fin = 1; tick; fin = 0;
        tick;
        checks++;
        if (frame_valid !== 1'b1 || frame_last !== 1'b1 || frame_data !== {TAG, mdl_trig[7:0], 8'h00}) begin
            failures++;
            $display("FAIL empty_header: valid=%b last=%b data=%h required 1 1 %h", frame_valid, frame_last, frame_data, {TAG, mdl_trig[7:0], 8'h00});
        end
        trig = 1; tick; trig = 0;
        mdl_miss++;
        checks++;
        if (miss_cnt !== 16'(mdl_miss) || trig_cnt !== mdl_trig || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL busy_trigger: miss=%0d trig=%0d valid=%b required miss=%0d trig=%0d valid=1", miss_cnt, trig_cnt, frame_valid, mdl_miss, mdl_trig);
        end
        frame_ready = 1; tick; frame_ready = 0;
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL empty_done: valid=%b busy=%b required 0 1", frame_valid, busy);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_random;
        int nw;
        int nwr;
        for (int f = 0; f < 8; f++) begin
            nwr = $urandom_range(22);
            run_frame(nwr, $urandom_range(2), 1'($urandom_range(1)), 1, 1, nw);
            checks++;
            if (nw != 1 + 2 * ((nwr > DEPTH) ? DEPTH : nwr)) begin
                failures++;
                $display("FAIL rand_count%0d: %0d words for %0d results", f, nw, nwr);
            end
        end
    endtask

    task automatic test_reset_midframe;
        bit found;
        int nw;
        int still;
        trig = 1; tick; trig = 0;
        for (int k = 0; k < 8; k++) begin
            wren = 1;
            data = {32'(k), 32'(256 + k)};
            tick;
        end
        wren = 0;
        fin = 1; tick; fin = 0;
        frame_ready = 1;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (frame_valid === 1'b1 && frame_data === 32'd5) found = 1;
            else tick;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midframe_reach: I word of entry 5 never presented");
        end
        rst_n = 0;
        #1;
        checks++;
        if ({frame_data, frame_valid, frame_last, trig_cnt, miss_cnt, ovf_flag, busy} !== '0) begin
            failures++;
            $display("FAIL midframe_reset: data=%h valid=%b last=%b trig=%h miss=%h ovf=%b busy=%b required all 0",
                     frame_data, frame_valid, frame_last, trig_cnt, miss_cnt, ovf_flag, busy);
        end
        repeat (2) tick;
        rst_n = 1;
        mdl_trig = 0; mdl_miss = 0; mdl_ovf = 0;
        still = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (frame_valid !== 1'b0 || busy !== 1'b0) still++;
        end
        frame_ready = 0;
        checks++;
        if (still != 0) begin
            failures++;
            $display("FAIL midframe_abort: %0d cycles with activity after reset, required 0", still);
        end
        run_frame(5, 2, 0, 1, 0, nw);
        checks++;
        if (nw != 11 || trig_cnt !== 16'd1) begin
            failures++;
            $display("FAIL post_reset_frame: %0d words trig=%0d required 11 words trig=1", nw, trig_cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_simultaneous;
        test_overflow;
        test_empty_and_miss;
        test_random;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pstprc_iq_collector.md
PSTPRC_IQ_COLLECTOR -- requirements
Module: pstprc_iq_collector

Interface
REQ-001 Parameter C_DEPTH, default 16: result buffer entries; power of two.
REQ-002 Parameter C_HDR_TAG, default 16'hA5C3: header tag, upper 16 bits of the header word.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 posedge_sample_trig  input  1  one-cycle trigger pulse; opens a collection frame.
REQ-006 pstprc_IQ_seq_i  input  64  demod result; [63:32] is I, [31:0] is Q.
REQ-007 pstprc_fifo_wren  input  1  result strobe; qualifies pstprc_IQ_seq_i for one cycle.
REQ-008 Pstprc_finish  input  1  one-cycle pulse; the demod has emitted all results for this trigger.
REQ-009 frame_data  output  32  upstream word.
REQ-010 frame_valid  output  1  frame_data is valid.
REQ-011 frame_ready  input  1  upstream accepts; a transfer occurs when frame_valid=1 and frame_ready=1 in the same cycle.
REQ-012 frame_last  output  1  marks the final word of a frame; valid only with frame_valid.
REQ-013 trig_cnt  output  16  count of frames opened since reset.
REQ-014 miss_cnt  output  16  count of triggers ignored because the block was busy.
REQ-015 ovf_flag  output  1  sticky flag: a result was dropped because the buffer was full.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The state machine SHALL have the states IDLE, COLLECT, HEADER, SEND_I, SEND_Q and DONE.
REQ-018 IDLE: a trigger SHALL move the block to COLLECT, clear the write pointer and increment trig_cnt, which wraps 0xFFFF->0.
REQ-019 COLLECT: each wren cycle with wr_ptr<C_DEPTH SHALL write the 64-bit result at wr_ptr and then increment wr_ptr.
REQ-020 COLLECT: a wren cycle with wr_ptr==C_DEPTH SHALL drop the result and set ovf_flag, which stays set until reset.
REQ-021 COLLECT: Pstprc_finish SHALL latch n_res=wr_ptr and move the block to HEADER on the next cycle.
REQ-022 If wren and Pstprc_finish occur in the same cycle, the result SHALL be stored first and counted in n_res.
REQ-023 HEADER: frame_data SHALL be {C_HDR_TAG, trig_cnt[7:0], n_res[7:0]}; frame_last=1 if and only if n_res==0.
REQ-024 SEND_I SHALL present I[rd_ptr] and SEND_Q SHALL present Q[rd_ptr].
- Order after HEADER: I0, Q0, I1, Q1, and so on.
- rd_ptr SHALL increment after each Q transfer.
REQ-025 frame_last SHALL be 1 on the Q word of entry n_res-1.
REQ-026 The state SHALL advance only on a transfer.
- While frame_valid=1 and frame_ready=0: frame_data and frame_last SHALL hold stable and frame_valid SHALL stay high.
REQ-027 frame_valid SHALL be high in HEADER, SEND_I and SEND_Q and low in every other state.
REQ-028 frame_valid SHALL not depend combinationally on frame_ready, and the outputs SHALL be registered.
REQ-029 The transfer of the frame_last word SHALL move the block to DONE; DONE SHALL return to IDLE on the next cycle.
REQ-030 A trigger in any state other than IDLE SHALL be ignored and SHALL increment miss_cnt, which saturates at 0xFFFF.
REQ-031 wren outside COLLECT SHALL be ignored; it does not set ovf_flag.
REQ-032 Pstprc_finish outside COLLECT SHALL be ignored.
REQ-033 Latency: the first frame_valid SHALL come 2 cycles after the finish pulse (finish at cycle N -> HEADER valid at cycle N+2).
REQ-034 With frame_ready held high, the block SHALL emit one word per cycle and 1+2*n_res words per frame.
REQ-035 Full-depth frame (n_res=C_DEPTH): rd_ptr and the counters SHALL NOT wrap inside the frame.

Reset
REQ-036 When rst_n=0, state SHALL go to IDLE immediately, with no wait for a clock edge.
REQ-037 Reset SHALL clear to 0: frame_data, frame_valid, frame_last, trig_cnt, miss_cnt, ovf_flag, busy, wr_ptr, rd_ptr and n_res.
REQ-038 Buffer contents need not be cleared.
REQ-039 Reset during a frame SHALL abort the frame; no further words of it SHALL be emitted after rst_n returns high.

Verification
REQ-040 Basic frame:
- Stimulus: trigger, 12 wren with I=k, Q=0x100+k, then finish; frame_ready held 1.
- Response: 25 words; header 0xA5C3_010C; then 0,0x100,1,0x101,...,11,0x10B; frame_last on 0x10B only.
REQ-041 Backpressure:
- Stimulus: same stimulus; frame_ready toggles 1/0 every cycle.
- Response: identical word sequence; no word lost or duplicated; data stable while stalled.
REQ-042 Overflow:
- Stimulus: 20 wren in one frame.
- Response: n_res=16, ovf_flag=1, header low byte 0x10, 33 words emitted.
REQ-043 Empty frame and busy trigger:
- Stimulus: trigger then finish with no wren; then a trigger during HEADER.
- Response: a single header word with frame_last=1 and low byte 0x00; miss_cnt=1.
- Response: trig_cnt=1, so the trigger in HEADER does not open a frame.
REQ-044 Simultaneous wren and finish:
- Stimulus: 3 wren, the last one in the same cycle as finish.
- Response: n_res=3; 7 words emitted.
REQ-045 Reset mid-frame:
- Stimulus: assert rst_n=0 during SEND_I of entry 5.
- Response: all outputs 0 immediately.
- Response: the next trigger yields trig_cnt=1 and a clean frame.
